// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the 5-stage MIPS hazard controller.
//   state_t   : hazard sequencer states (INIT / RUN / MD_WAIT)
//   FWD_*     : ALU operand forwarding mux selects
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;  // register file
    localparam logic [1:0] FWD_W  = 2'b01;  // writeback stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // memory stage result

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Purely combinational forwarding selection.
// Ports:
//   rs_d, rt_d           : Decode source registers (branch comparator)
//   rs_e, rt_e           : Execute source registers (ALU operands)
//   write_reg_m/_w       : destination registers in Memory / Writeback
//   reg_write_m/_w       : write enables in Memory / Writeback
//   forward_a_e/_b_e     : ALU operand selects (FWD_RF / FWD_W / FWD_M)
//   forward_a_d/_b_d     : branch comparator forward-from-M selects
// Memory has priority over Writeback; register $0 is never forwarded.
// -----------------------------------------------------------------------------
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rt_e,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic [REG_ADDR_W-1:0] write_reg_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  forward_a_d,
    output logic                  forward_b_d
);

    logic m_valid;
    logic w_valid;

    always_comb begin
        m_valid = reg_write_m && (write_reg_m != '0);
        w_valid = reg_write_w && (write_reg_w != '0);

        forward_a_e = FWD_RF;
        if (m_valid && (write_reg_m == rs_e))
            forward_a_e = FWD_M;
        else if (w_valid && (write_reg_w == rs_e))
            forward_a_e = FWD_W;

        forward_b_e = FWD_RF;
        if (m_valid && (write_reg_m == rt_e))
            forward_b_e = FWD_M;
        else if (w_valid && (write_reg_w == rt_e))
            forward_b_e = FWD_W;

        forward_a_d = m_valid && (write_reg_m == rs_d);
        forward_b_d = m_valid && (write_reg_m == rt_d);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard / sequencing controller for the 5-stage MIPS core.
// Generates stall, flush and forwarding controls for the F/D, D/E and E/M
// pipeline registers, fills the pipe with bubbles after reset, and holds the
// pipe while a multi-cycle MUL/DIV occupies Execute (with a watchdog).
//
// Ports:
//   CLK, RST                     : clock, asynchronous active-low reset
//   RsD, RtD, RsE, RtE           : source registers in Decode / Execute
//   WriteRegE/M/W, RegWriteE/M/W : destination registers / write enables
//   MemtoRegE, MemtoRegM         : load in Execute / Memory
//   BranchD, PCSrcD              : branch in Decode, branch/jump taken
//   MdStartE, MdDone             : MUL/DIV in Execute (level), result pulse
//   StallF, StallD, StallE       : hold PC / F-D / D-E registers
//   FlushD, FlushE               : clear F-D / D-E registers
//   ForwardAE/BE, ForwardAD/BD   : forwarding selects
//   MdBusy, MdTimeout            : MUL/DIV wait, sticky watchdog error
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating counters
//   StallCnt (StallD cycles in RUN/MD_WAIT), FlushCnt (FlushE cycles in RUN),
//   MdCnt (entries into MD_WAIT).
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned FILL_CYCLES = 4,
    parameter int unsigned MD_TIMEOUT  = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  MemtoRegM,
    input  logic                  BranchD,
    input  logic                  PCSrcD,
    input  logic                  MdStartE,
    input  logic                  MdDone,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic                  MdBusy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           StallCnt,
    output logic [31:0]           FlushCnt,
    output logic [15:0]           MdCnt,
`endif
    output logic                  MdTimeout
);

    state_t     state, state_nxt;
    logic [3:0] fill_cnt, fill_nxt;
    logic [7:0] wd_cnt, wd_nxt;
    logic       timeout_q, timeout_nxt;
    logic       lwstall, brstall, hazard;

    fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .rs_d        (RsD),
        .rt_d        (RtD),
        .rs_e        (RsE),
        .rt_e        (RtE),
        .write_reg_m (WriteRegM),
        .write_reg_w (WriteRegW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .forward_a_e (ForwardAE),
        .forward_b_e (ForwardBE),
        .forward_a_d (ForwardAD),
        .forward_b_d (ForwardBD)
    );

    always_comb begin
        lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        brstall = BranchD &&
                  ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                   (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
        hazard  = lwstall || brstall;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= INIT;
            fill_cnt  <= 4'(FILL_CYCLES - 1);
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            wd_cnt    <= wd_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fill_nxt    = fill_cnt;
        wd_nxt      = wd_cnt;
        timeout_nxt = timeout_q;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        MdBusy      = 1'b0;

        case (state)
            INIT: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (fill_cnt == '0)
                    state_nxt = RUN;
                else
                    fill_nxt = fill_cnt - 4'd1;
            end
            RUN: begin
                StallF = hazard;
                StallD = hazard;
                FlushE = hazard;
                // A stalled decode must keep its instruction even if a
                // taken branch/jump is reported in the same cycle.
                FlushD = PCSrcD && !hazard;
                if (MdStartE && !MdDone) begin
                    state_nxt = MD_WAIT;
                    wd_nxt    = 8'(MD_TIMEOUT - 1);
                end
            end
            MD_WAIT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                MdBusy = 1'b1;
                // Completion takes precedence over watchdog expiry.
                if (MdDone) begin
                    state_nxt = RUN;
                end else if (wd_cnt == '0) begin
                    state_nxt   = RUN;
                    timeout_nxt = 1'b1;
                end else begin
                    wd_nxt = wd_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = INIT;
                fill_nxt  = 4'(FILL_CYCLES - 1);
            end
        endcase
    end

    assign MdTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            MdCnt    <= '0;
        end else begin
            if (StallD && (state == RUN || state == MD_WAIT) && StallCnt != '1)
                StallCnt <= StallCnt + 32'd1;
            if (FlushE && state == RUN && FlushCnt != '1)
                FlushCnt <= FlushCnt + 32'd1;
            if (state == RUN && state_nxt == MD_WAIT && MdCnt != '1)
                MdCnt <= MdCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned FILL = 4;
    localparam int unsigned MDT  = 12;

    typedef struct packed {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pc_d, md_start, md_done;
    } in_t;

    typedef struct packed {
        logic       sf, sd, se, fd, fe;
        logic [1:0] fae, fbe;
        logic       fad, fbd, busy, tmo;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, MdStartE, MdDone;
    logic       StallF, StallD, StallE, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, MdBusy, MdTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
    logic [15:0] MdCnt;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];
    logic  sticky_tmo = 1'b0;
    int unsigned exp_stall = 0, exp_flush = 0, exp_md = 0;
    logic  prev_busy = 1'b0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(
        .REG_ADDR_W  (5),
        .FILL_CYCLES (FILL),
        .MD_TIMEOUT  (MDT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegE (WriteRegE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteE (RegWriteE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .MemtoRegE (MemtoRegE),
        .MemtoRegM (MemtoRegM),
        .BranchD   (BranchD),
        .PCSrcD    (PCSrcD),
        .MdStartE  (MdStartE),
        .MdDone    (MdDone),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .MdBusy    (MdBusy),
`ifdef HAZARD_PERF_CNT_EN
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt),
        .MdCnt     (MdCnt),
`endif
        .MdTimeout (MdTimeout)
    );

    localparam out_t O_IDLE = '0;
    localparam out_t O_INIT = out_t'{fd: 1'b1, fe: 1'b1, default: 0};
    localparam out_t O_STL  = out_t'{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: 0};
    localparam out_t O_MD   = out_t'{sf: 1'b1, sd: 1'b1, se: 1'b1, busy: 1'b1, default: 0};
    localparam in_t  I_ZERO = '0;
    localparam in_t  I_MD   = in_t'{md_start: 1'b1, default: 0};
    localparam in_t  I_MDD  = in_t'{md_start: 1'b1, md_done: 1'b1, default: 0};

    task automatic drive(input in_t i);
        RsD = i.rs_d; RtD = i.rt_d; RsE = i.rs_e; RtE = i.rt_e;
        WriteRegE = i.wr_e; WriteRegM = i.wr_m; WriteRegW = i.wr_w;
        RegWriteE = i.rw_e; RegWriteM = i.rw_m; RegWriteW = i.rw_w;
        MemtoRegE = i.m2r_e; MemtoRegM = i.m2r_m;
        BranchD = i.br_d; PCSrcD = i.pc_d;
        MdStartE = i.md_start; MdDone = i.md_done;
    endtask

    task automatic check_now();
        out_t  e, a;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE,
                 ForwardAD, ForwardBD, MdBusy, MdTimeout};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got sf sd se fd fe fae fbe fad fbd busy tmo=%b required=%b",
                         n, a, e);
            end
        end
    endtask

    task automatic push(input string n, input out_t e);
        out_t x;
        x = e;
        x.tmo = e.tmo | sticky_tmo;
        exp_q.push_back(x);
        name_q.push_back(n);
        // Reference counts for the optional performance counters.
        exp_stall += int'(x.sd);
        exp_flush += int'(x.fe && !x.fd);
        if (x.busy && !prev_busy) exp_md++;
        prev_busy = x.busy;
    endtask

    task automatic sample(input string n, input out_t e);
        push(n, e);
        @(negedge CLK);
        check_now();
    endtask

    task automatic step(input string n, input in_t i, input out_t e);
        @(posedge CLK);
        #1;
        drive(i);
        sample(n, e);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RST = 1'b0;
        drive(I_ZERO);
        sticky_tmo = 1'b0;
        exp_q.push_back(O_INIT);
        name_q.push_back("rst_async");
        #1;
        check_now();
        exp_stall = 0; exp_flush = 0; exp_md = 0; prev_busy = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (StallCnt !== 0 || FlushCnt !== 0 || MdCnt !== 0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d/%0d required 0/0/0",
                     StallCnt, FlushCnt, MdCnt);
        end
`endif
        @(posedge CLK);
        #1;
        RST = 1'b1;
        sample("init_fill", O_INIT);
        for (int k = 1; k < int'(FILL); k++) step("init_fill", I_ZERO, O_INIT);
        step("init_to_run", I_ZERO, O_IDLE);
    endtask

    task automatic add(input string n, input in_t i, input out_t e);
        vec_t v;
        v.name = n; v.in = i; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(I_ZERO);

        add("idle", I_ZERO, O_IDLE);
        add("fwdA_M_over_W",
            in_t'{rw_m: 1'b1, wr_m: 5'd8, rs_e: 5'd8, rw_w: 1'b1, wr_w: 5'd8, default: 0},
            out_t'{fae: 2'b10, default: 0});
        add("fwdA_reg0",
            in_t'{rw_m: 1'b1, rw_w: 1'b1, default: 0}, O_IDLE);
        add("fwdB_W",
            in_t'{rw_w: 1'b1, wr_w: 5'd9, rt_e: 5'd9, rw_m: 1'b1, wr_m: 5'd3, default: 0},
            out_t'{fbe: 2'b01, default: 0});
        add("fwdA_W_fwdB_M",
            in_t'{rw_m: 1'b1, wr_m: 5'd2, rt_e: 5'd2, rw_w: 1'b1, wr_w: 5'd1, rs_e: 5'd1, default: 0},
            out_t'{fae: 2'b01, fbe: 2'b10, default: 0});
        add("fwd_D",
            in_t'{rw_m: 1'b1, wr_m: 5'd7, rs_d: 5'd7, rt_d: 5'd7, default: 0},
            out_t'{fad: 1'b1, fbd: 1'b1, default: 0});
        add("fwd_D_nowrite",
            in_t'{wr_m: 5'd7, rs_d: 5'd7, default: 0}, O_IDLE);
        add("lwstall_rs",
            in_t'{m2r_e: 1'b1, rt_e: 5'd5, rs_d: 5'd5, default: 0}, O_STL);
        add("lwstall_pcsrc",
            in_t'{m2r_e: 1'b1, rt_e: 5'd5, rs_d: 5'd5, pc_d: 1'b1, default: 0}, O_STL);
        add("pcsrc_flush",
            in_t'{pc_d: 1'b1, default: 0}, out_t'{fd: 1'b1, default: 0});
        add("brstall_E",
            in_t'{br_d: 1'b1, rw_e: 1'b1, wr_e: 5'd4, rt_d: 5'd4, default: 0}, O_STL);
        add("brstall_Mload",
            in_t'{br_d: 1'b1, m2r_m: 1'b1, wr_m: 5'd6, rs_d: 5'd6, default: 0}, O_STL);
        add("branch_nohaz",
            in_t'{br_d: 1'b1, wr_e: 5'd4, rs_d: 5'd4, pc_d: 1'b1, default: 0},
            out_t'{fd: 1'b1, default: 0});
        add("lwstall_rt",
            in_t'{m2r_e: 1'b1, rt_e: 5'd3, rt_d: 5'd3, default: 0}, O_STL);

        do_reset();

        foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);

        // MUL/DIV completing after 10 wait cycles
        step("mdA_issue", I_MD, O_IDLE);
        for (int k = 1; k < 10; k++) step("mdA_wait", I_MD, O_MD);
        step("mdA_done", I_MDD, O_MD);
        step("mdA_exit", I_ZERO, O_IDLE);

        // single-cycle completion never enters MD_WAIT
        step("mdB_same", I_MDD, O_IDLE);
        step("mdB_after", I_ZERO, O_IDLE);

        // done on the watchdog expiry cycle: no timeout
        step("mdD_issue", I_MD, O_IDLE);
        for (int k = 1; k < int'(MDT); k++) step("mdD_wait", I_MD, O_MD);
        step("mdD_done_at_expiry", I_MDD, O_MD);
        step("mdD_exit_no_tmo", I_ZERO, O_IDLE);

        // watchdog expiry: forced release, sticky timeout
        step("mdC_issue", I_MD, O_IDLE);
        for (int k = 0; k < int'(MDT); k++) step("mdC_wait", I_MD, O_MD);
        sticky_tmo = 1'b1;
        step("mdC_release", I_ZERO, O_IDLE);
        step("mdC_sticky", in_t'{md_done: 1'b1, default: 0}, O_IDLE);
        step("mdC_sticky2", I_ZERO, O_IDLE);

`ifdef HAZARD_PERF_CNT_EN
        @(posedge CLK);
        #1;
        checks++;
        if (StallCnt !== exp_stall || FlushCnt !== exp_flush || MdCnt !== exp_md) begin
            errors++;
            $display("FAIL perf_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
                     StallCnt, FlushCnt, MdCnt, exp_stall, exp_flush, exp_md);
        end
`endif

        // asynchronous reset in the middle of MD_WAIT
        step("mdE_issue", I_MD, O_IDLE);
        for (int k = 0; k < 3; k++) step("mdE_wait", I_MD, O_MD);
        do_reset();
        step("post_reset_lwstall",
             in_t'{m2r_e: 1'b1, rt_e: 5'd5, rs_d: 5'd5, default: 0}, O_STL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/sequencing controller for the 5-stage MIPS core.
- Drives stall, flush and forwarding controls for the F/D, D/E (ID/EX) and E/M pipeline registers.
- Sequences a post-reset bubble-fill phase and multi-cycle MUL/DIV occupancy of the Execute stage, with a watchdog.
- Sits beside the datapath: reads register addresses and control bits from the D, E, M and W stages.

Parameters:
REG_ADDR_W, 5, register address width (RsX/RtX/WriteRegX)
FILL_CYCLES, 4, bubble cycles forced after reset deassertion (1..15)
MD_TIMEOUT, 64, max MUL/DIV busy cycles before error (2..255)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
RsD, RtD  in  REG_ADDR_W  source regs in Decode
RsE, RtE  in  REG_ADDR_W  source regs in Execute
WriteRegE, WriteRegM, WriteRegW  in  REG_ADDR_W  destination regs per stage
RegWriteE, RegWriteM, RegWriteW  in  1  write-enable per stage
MemtoRegE, MemtoRegM  in  1  load in stage
BranchD  in  1  branch in Decode
PCSrcD  in  1  branch/jump taken, resolved in Decode
MdStartE  in  1  multi-cycle MUL/DIV instruction in Execute (level)
MdDone  in  1  MUL/DIV unit result valid (1-cycle pulse)
StallF, StallD, StallE  out  1  hold PC / F-D / D-E registers
FlushD, FlushE  out  1  clear F-D / D-E registers
ForwardAE, ForwardBE  out  2  ALU operand mux select: 00 RF, 01 W, 10 M
ForwardAD, ForwardBD  out  1  branch comparator forward from M
MdBusy  out  1  FSM in MD_WAIT
MdTimeout  out  1  sticky watchdog error

Behaviour:
- Reset: RST low asynchronously forces state INIT and fill counter = FILL_CYCLES-1. MdTimeout=0. Outputs follow the INIT row below.
- Forwarding (combinational, valid in every state):
  - ForwardAE=10 if RegWriteM & WriteRegM!=0 & WriteRegM==RsE.
  - Else ForwardAE=01 if RegWriteW & WriteRegW!=0 & WriteRegW==RsE.
  - Else ForwardAE=00.
  - ForwardBE: same rule using RtE.
  - ForwardAD=RegWriteM & WriteRegM!=0 & WriteRegM==RsD; ForwardBD same rule using RtD.
  - M has priority over W. Register $0 is never forwarded.
- Hazard terms:
  - lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
  - brstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
- FSM states and transitions:
  - INIT: StallF=StallD=StallE=0, FlushD=FlushE=1. Counter decrements each cycle; at 0 -> RUN. Exactly FILL_CYCLES cycles after RST rises.
  - RUN:
    - StallF=StallD=lwstall|brstall, StallE=0, FlushE=lwstall|brstall.
    - FlushD=PCSrcD & ~StallD.
    - MdStartE=1 & MdDone=0 -> MD_WAIT: enter on the next edge and load the watchdog with MD_TIMEOUT-1.
    - MdStartE=1 & MdDone=1 in the same cycle: single-cycle completion, remain in RUN.
  - MD_WAIT:
    - StallF=StallD=StallE=1, FlushD=FlushE=0. MdBusy=1.
    - lwstall, brstall and PCSrcD are ignored: the E instruction holds, so D hazards are re-evaluated after exit.
    - MdDone=1 -> RUN; that cycle's outputs are still MD_WAIT outputs.
    - Watchdog decrements each cycle; reaching 0 without MdDone -> set MdTimeout and go to RUN (forced release).
- Simultaneous events:
  - MdDone and watchdog expiry in the same cycle: treat as done; MdTimeout is not set.
  - lwstall and PCSrcD together in RUN: the stall wins and FlushD=0.
- Reset mid-MD_WAIT: immediate return to INIT; the watchdog is discarded.
- MdTimeout is cleared only by RST.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add outputs:
  - StallCnt (32): cycles with StallD=1 in RUN or MD_WAIT.
  - FlushCnt (32): cycles with FlushE=1 in RUN only.
  - MdCnt (16): entries into MD_WAIT.
- All counters reset to 0 and saturate at all-ones.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - state encoding localparams: INIT=2'd0, RUN=2'd1, MD_WAIT=2'd2.
  - forward select constants: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- Sub-module fwd_unit (purely combinational) computes ForwardAE/BE/AD/BD. Instantiated once; the FSM, counters and stall/flush logic stay in hazard_ctrl.

Test Plan:
- Reset then release with FILL_CYCLES=4 -> FlushD=FlushE=1 for exactly 4 cycles, then 0 with state RUN.
- RegWriteM=1, WriteRegM=8, RsE=8, and RegWriteW=1, WriteRegW=8 -> ForwardAE=10. Repeat with WriteRegM=0 and RsE=0 -> ForwardAE=00.
- MemtoRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1 for 1 cycle. With PCSrcD=1 in the same cycle -> FlushD=0.
- MdStartE=1, MdDone pulses 10 cycles later -> MdBusy and StallE high for 10 cycles, then RUN. Also MdStartE and MdDone in the same cycle -> no MD_WAIT entry.
- MD_TIMEOUT=8 with MdDone never asserted -> 8 stall cycles, then MdTimeout=1 sticky and RUN. MdDone exactly on the expiry cycle -> MdTimeout stays 0.
- RST asserted mid-MD_WAIT -> outputs go to INIT values immediately, asynchronously. With HAZARD_PERF_CNT_EN, StallCnt/FlushCnt/MdCnt match the cycle counts above.
